sand_update_sequencer: RTL

//  Frame-update controller for the dual-read/single-write cell register file.

---
 rtl/sand_update_sequencer.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/sand_update_sequencer.sv
// ============================================================================
// Module      : sand_update_sequencer
// Description : Per-frame bottom-up sand scan over a dual-read/single-write
//               cell register file. Optional macro SAND_DIAGONAL_EN adds
//               diagonal slides when the cell below is occupied.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sand_update_sequencer #(
    parameter int                    H_RES      = 640,
    parameter int                    V_RES      = 480,
    parameter int                    ADDR_WIDTH = 19,
    parameter int                    DATA_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0] EMPTY_CODE = 8'h00,
    parameter logic [DATA_WIDTH-1:0] SAND_CODE  = 8'h01
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [DATA_WIDTH-1:0] read_data_1_i,
    input  logic [DATA_WIDTH-1:0] read_data_2_i,
    output logic [ADDR_WIDTH-1:0] read_address_1_o,
    output logic [ADDR_WIDTH-1:0] read_address_2_o,
    output logic                  write_en_o,
    output logic [ADDR_WIDTH-1:0] write_address_o,
    output logic [DATA_WIDTH-1:0] write_data_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [15:0]           moves_o
);

    localparam int X_W = (H_RES > 1) ? $clog2(H_RES) : 1;
    localparam int Y_W = (V_RES > 1) ? $clog2(V_RES) : 1;

    localparam logic [X_W-1:0]        X_LAST   = X_W'(H_RES - 1);
    localparam logic [Y_W-1:0]        Y_FIRST  = Y_W'(V_RES - 2);
    localparam logic [ADDR_WIDTH-1:0] A_SRC0   = ADDR_WIDTH'((V_RES - 2) * H_RES);
    localparam logic [ADDR_WIDTH-1:0] A_BELOW0 = ADDR_WIDTH'((V_RES - 1) * H_RES);
    // From (H_RES-1, y) back to (0, y-1)
    localparam logic [ADDR_WIDTH-1:0] ROW_BACK = ADDR_WIDTH'(2 * H_RES - 1);
    localparam logic [ADDR_WIDTH-1:0] A_ONE    = ADDR_WIDTH'(1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_READ   = 3'd1;
    localparam logic [2:0] S_EVAL   = 3'd2;
    localparam logic [2:0] S_WR_SRC = 3'd3;
    localparam logic [2:0] S_WR_DST = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;
`ifdef SAND_DIAGONAL_EN
    localparam logic [2:0] S_DREAD  = 3'd6;
    localparam logic [2:0] S_DEVAL  = 3'd7;
`endif

    logic [2:0]            state_q, state_d;
    logic [X_W-1:0]        x_q, x_d;
    logic [Y_W-1:0]        y_q, y_d;
    logic [ADDR_WIDTH-1:0] src_q, src_d;
    logic [ADDR_WIDTH-1:0] below_q, below_d;
    logic [ADDR_WIDTH-1:0] dst_q, dst_d;
    logic [15:0]           count_q, count_d;
    logic [15:0]           moves_q, moves_d;
    logic                  advance;

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        src_d   = src_q;
        below_d = below_q;
        dst_d   = dst_q;
        count_d = count_q;
        moves_d = moves_q;
        advance = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    x_d     = '0;
                    y_d     = Y_FIRST;
                    src_d   = A_SRC0;
                    below_d = A_BELOW0;
                    count_d = '0;
                    state_d = S_READ;
                end
            end
            S_READ: state_d = S_EVAL;
            S_EVAL: begin
                if (read_data_1_i == SAND_CODE) begin
                    if (read_data_2_i == EMPTY_CODE) begin
                        dst_d   = below_q;
                        state_d = S_WR_SRC;
                    end else begin
`ifdef SAND_DIAGONAL_EN
                        state_d = S_DREAD;
`else
                        advance = 1'b1;
`endif
                    end
                end else begin
                    advance = 1'b1;
                end
            end
`ifdef SAND_DIAGONAL_EN
            S_DREAD: state_d = S_DEVAL;
            S_DEVAL: begin
                if ((x_q != '0) && (read_data_1_i == EMPTY_CODE)) begin
                    dst_d   = below_q - A_ONE;
                    state_d = S_WR_SRC;
                end else if ((x_q != X_LAST) && (read_data_2_i == EMPTY_CODE)) begin
                    dst_d   = below_q + A_ONE;
                    state_d = S_WR_SRC;
                end else begin
                    advance = 1'b1;
                end
            end
`endif
            S_WR_SRC: state_d = S_WR_DST;
            S_WR_DST: begin
                if (count_q != 16'hFFFF) begin
                    count_d = count_q + 16'd1;
                end
                advance = 1'b1;
            end
            S_DONE: begin
                moves_d = count_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (advance) begin
            if ((x_q == X_LAST) && (y_q == '0)) begin
                state_d = S_DONE;
            end else if (x_q == X_LAST) begin
                x_d     = '0;
                y_d     = y_q - Y_W'(1);
                src_d   = src_q - ROW_BACK;
                below_d = below_q - ROW_BACK;
                state_d = S_READ;
            end else begin
                x_d     = x_q + X_W'(1);
                src_d   = src_q + A_ONE;
                below_d = below_q + A_ONE;
                state_d = S_READ;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            src_q   <= '0;
            below_q <= '0;
            dst_q   <= '0;
            count_q <= '0;
            moves_q <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            src_q   <= src_d;
            below_q <= below_d;
            dst_q   <= dst_d;
            count_q <= count_d;
            moves_q <= moves_d;
        end
    end

    always_comb begin
        read_address_1_o = '0;
        read_address_2_o = '0;
        write_en_o       = 1'b0;
        write_address_o  = '0;
        write_data_o     = '0;
        case (state_q)
            S_READ, S_EVAL: begin
                read_address_1_o = src_q;
                read_address_2_o = below_q;
            end
`ifdef SAND_DIAGONAL_EN
            // Edge columns re-read the cell below rather than wrap into another row
            S_DREAD, S_DEVAL: begin
                read_address_1_o = (x_q == '0)    ? below_q : below_q - A_ONE;
                read_address_2_o = (x_q == X_LAST) ? below_q : below_q + A_ONE;
            end
`endif
            S_WR_SRC: begin
                write_en_o      = 1'b1;
                write_address_o = src_q;
                write_data_o    = EMPTY_CODE;
            end
            S_WR_DST: begin
                write_en_o      = 1'b1;
                write_address_o = dst_q;
                write_data_o    = SAND_CODE;
            end
            default: ;
        endcase
    end

    assign busy_o  = (state_q != S_IDLE);
    assign done_o  = (state_q == S_DONE);
    assign moves_o = moves_q;

endmodule

`default_nettype wire
